// File: rtl/sopc_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-port SOPC RAM with fixed wait states.
// Build option ARB_ROUND_ROBIN_EN: alternate the winner on contention; otherwise data beats fetch.
module sopc_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_ack,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_we,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W/8-1:0] data_sel,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_ack,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_ce,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_sel,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_req,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic       GNT_DATA = 1'b0;
   localparam logic       GNT_INST = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                grant_q, grant_d;
   logic                inst_ack_q, inst_ack_d;
   logic                data_ack_q, data_ack_d;
   logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
   logic                win;

`ifdef ARB_ROUND_ROBIN_EN
   logic                last_grant_q, last_grant_d;

   // Contention goes to whichever port did not win last time.
   always_comb begin
      if (inst_req && data_req) win = ~last_grant_q;
      else                      win = inst_req ? GNT_INST : GNT_DATA;
   end
`else
   assign win = data_req ? GNT_DATA : GNT_INST;
`endif

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      inst_ack_d   = 1'b0;
      data_ack_d   = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (inst_req || data_req) begin
               grant_d = win;
               cnt_d   = CNT_INIT;
               state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = win;
`endif
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               if (grant_q == GNT_INST) begin
                  inst_rdata_d = mem_rdata;
                  inst_ack_d   = 1'b1;
               end else begin
                  // A store leaves the load-data register untouched.
                  if (!data_we) data_rdata_d = mem_rdata;
                  data_ack_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         grant_q      <= GNT_DATA;
         inst_ack_q   <= 1'b0;
         data_ack_q   <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= GNT_DATA;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         inst_ack_q   <= inst_ack_d;
         data_ack_q   <= data_ack_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Memory strobes decode the registered state; address and data follow the held requester fields.
   always_comb begin
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_sel   = '0;
      mem_wdata = '0;
      if (state_q == ACCESS) begin
         mem_ce = 1'b1;
         if (grant_q == GNT_INST) begin
            mem_addr = inst_addr;
            mem_sel  = '1;
         end else begin
            mem_we    = data_we;
            mem_addr  = data_addr;
            mem_sel   = data_sel;
            mem_wdata = data_wdata;
         end
      end
   end

   assign inst_ack   = inst_ack_q;
   assign data_ack   = data_ack_q;
   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;
   assign busy       = (state_q != IDLE);
   assign stall_req  = (inst_req & ~inst_ack_q) | (data_req & ~data_ack_q);

endmodule
